// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common-data-bus writeback arbiter with per-channel result FIFOs
//
// Collects completed results from NUM_CH functional-unit channels into small
// per-channel FIFOs and broadcasts at most one per cycle, round-robin, on a
// registered CDB (rename wakeup, RS tag match, ROB completion, regfile write).
//
// Optional feature: define CDB_BYPASS_EN to let a valid input go straight into
// the output register when every FIFO is empty and the register is loading.
//
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - asynchronous active-high reset
//   wb_valid_i   - per-channel result valid
//   wb_tag_i     - per-channel destination tag, channel c at [c*TAG_W +: TAG_W]
//   wb_value_i   - per-channel result value, channel c at [c*DATA_W +: DATA_W]
//   wb_ready_o   - per-channel FIFO can accept a result (registered count only)
//   cdb_stall_i  - consumer cannot accept the current broadcast
//   cdb_en_o     - broadcast valid
//   cdb_tag_o    - broadcast tag
//   cdb_value_o  - broadcast value
//   cdb_ch_o     - source channel of the broadcast
module cdb_arbiter #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_CH-1:0]         wb_valid_i,
  input  logic [NUM_CH*TAG_W-1:0]   wb_tag_i,
  input  logic [NUM_CH*DATA_W-1:0]  wb_value_i,
  output logic [NUM_CH-1:0]         wb_ready_o,
  input  logic                      cdb_stall_i,
  output logic                      cdb_en_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_value_o,
  output logic [$clog2(NUM_CH)-1:0] cdb_ch_o
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [ENT_W-1:0] mem    [NUM_CH][BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_CH];
  logic [PTR_W-1:0] wr_ptr [NUM_CH];
  logic [CNT_W-1:0] count  [NUM_CH];
  logic [CH_W-1:0]  rr_ptr;

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] enq;
  logic [NUM_CH-1:0] pop;
  logic              load;
  logic              fifo_hit;
  logic [CH_W-1:0]   fifo_ch;
  logic [ENT_W-1:0]  fifo_head;
  logic              byp_hit;
  logic [CH_W-1:0]   byp_ch;
  logic [ENT_W-1:0]  byp_ent;

  // First set bit of req searching upward from start with wrap; MSB = found.
  // Iterating from the farthest offset down leaves the nearest hit in res.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CH_W-1:0]   start);
    logic [CH_W:0]   res;
    logic [CH_W-1:0] idx;
    int              s;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      s = int'(start) + i;
      if (s >= NUM_CH) s = s - NUM_CH;
      idx = CH_W'(s);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty[c]   = (count[c] != '0);
      wb_ready_o[c] = !reset_i && (count[c] < FULL);
    end
  end

  assign push = wb_valid_i & wb_ready_o;
  assign load = !cdb_en_o || !cdb_stall_i;
  assign {fifo_hit, fifo_ch} = rr_pick(nonempty, rr_ptr);

  always_comb begin
    fifo_head = '0;
    pop       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == fifo_ch) begin
        fifo_head = mem[c][rd_ptr[c]];
        pop[c]    = load && fifo_hit;
      end
    end
  end

`ifdef CDB_BYPASS_EN
  logic [CH_W:0] byp_pick;
  assign byp_pick = rr_pick(push, rr_ptr);
  // Bypass only when nothing is buffered anywhere, so FIFO order is preserved.
  assign byp_hit  = load && !fifo_hit && byp_pick[CH_W];
  assign byp_ch   = byp_pick[CH_W-1:0];

  always_comb begin
    byp_ent = '0;
    enq     = push;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == byp_ch) begin
        byp_ent = {wb_tag_i[c*TAG_W +: TAG_W], wb_value_i[c*DATA_W +: DATA_W]};
        if (byp_hit) enq[c] = 1'b0;
      end
    end
  end
`else
  assign byp_hit = 1'b0;
  assign byp_ch  = '0;
  assign byp_ent = '0;
  assign enq     = push;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr      <= '0;
      cdb_en_o    <= 1'b0;
      cdb_tag_o   <= '0;
      cdb_value_o <= '0;
      cdb_ch_o    <= '0;
    end else if (load) begin
      if (fifo_hit) begin
        cdb_en_o                 <= 1'b1;
        {cdb_tag_o, cdb_value_o} <= fifo_head;
        cdb_ch_o                 <= fifo_ch;
        rr_ptr                   <= next_ch(fifo_ch);
      end else if (byp_hit) begin
        cdb_en_o                 <= 1'b1;
        {cdb_tag_o, cdb_value_o} <= byp_ent;
        cdb_ch_o                 <= byp_ch;
        rr_ptr                   <= next_ch(byp_ch);
      end else begin
        // Data outputs deliberately hold their last values when idle.
        cdb_en_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (enq[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (enq[c] && !pop[c])      count[c] <= count[c] + CNT_W'(1);
        else if (!enq[c] && pop[c]) count[c] <= count[c] - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (enq[c]) mem[c][wr_ptr[c]] <= {wb_tag_i[c*TAG_W +: TAG_W], wb_value_i[c*DATA_W +: DATA_W]};
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter (default build)
module tb_cdb_arbiter;
    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [2:0]  wb_valid = '0;
    logic [14:0] wb_tag   = '0;
    logic [95:0] wb_value = '0;
    logic [2:0]  wb_ready;
    logic        stall    = 1'b0;
    logic        cdb_en;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [1:0]  cdb_ch;

    int n_cmp = 0;
    int n_err = 0;
    int seq     [3];
    int exp_seq [3];
    int grants  [3];
    int total_win;
    logic [2:0] acc;
    bit done = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_CH(3), .DATA_W(32), .TAG_W(5), .BUF_DEPTH(2)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .wb_valid_i  (wb_valid),
        .wb_tag_i    (wb_tag),
        .wb_value_i  (wb_value),
        .wb_ready_o  (wb_ready),
        .cdb_stall_i (stall),
        .cdb_en_o    (cdb_en),
        .cdb_tag_o   (cdb_tag),
        .cdb_value_o (cdb_value),
        .cdb_ch_o    (cdb_ch)
    );

    task automatic chk(input string nm, input logic [63:0] ob, input logic [63:0] ex);
        n_cmp++;
        if (ob !== ex) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, ob, ex);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic [4:0] t, input logic [31:0] v);
        wb_tag[c*5 +: 5]     = t;
        wb_value[c*32 +: 32] = v;
    endtask

    function automatic logic [4:0] stag(input int c, input int s);
        return {2'(c), 3'(s)};
    endfunction

    function automatic logic [31:0] sval(input int c, input int s);
        return (32'(c) << 28) | 32'(s);
    endfunction

    task automatic chk_bc(input string nm, input logic [4:0] t, input logic [1:0] ch);
        chk({nm, "_en"}, cdb_en, 1'b1);
        chk({nm, "_tag"}, cdb_tag, t);
        chk({nm, "_ch"}, cdb_ch, ch);
    endtask

    task automatic sb(input bit in_win);
        int c;
        c = int'(cdb_ch);
        chk("sb_ch_range", (c < 3), 1'b1);
        if (c < 3) begin
            chk("sb_tag", cdb_tag, stag(c, exp_seq[c]));
            chk("sb_value", cdb_value, sval(c, exp_seq[c]));
            exp_seq[c]++;
            if (in_win) grants[c]++;
        end
    endtask

    initial begin
        #200000;
        if (!done) begin
            n_err++;
            $error("FAIL timeout: bench did not complete");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_en", cdb_en, 1'b0);
        chk("rst_tag", cdb_tag, 5'd0);
        chk("rst_value", cdb_value, 32'd0);
        chk("rst_ch", cdb_ch, 2'd0);
        chk("rst_ready", wb_ready, 3'b000);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_ready", wb_ready, 3'b111);

        wb_valid = 3'b010;
        put(1, 5'd7, 32'hDEADBEEF);
        tick();
        wb_valid = 3'b000;
        chk("single_lat_en", cdb_en, 1'b0);
        tick();
        chk_bc("single", 5'd7, 2'd1);
        chk("single_value", cdb_value, 32'hDEADBEEF);
        tick();
        chk("single_once", cdb_en, 1'b0);
        chk("idle_hold_value", cdb_value, 32'hDEADBEEF);

        wb_valid = 3'b100;
        put(2, 5'h1F, 32'h12345678);
        tick();
        wb_valid = 3'b000;
        tick();
        chk_bc("wrap", 5'h1F, 2'd2);
        tick();
        chk("wrap_idle", cdb_en, 1'b0);

        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) put(c, 5'(r*3 + c + 1), 32'(32'h100 + r*3 + c + 1));
            wb_valid = 3'b111;
            tick();
            wb_valid = 3'b000;
            chk("rr_lat_en", cdb_en, 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk_bc("rr", 5'(r*3 + c + 1), 2'(c));
                chk("rr_value", cdb_value, 32'(32'h100 + r*3 + c + 1));
            end
            tick();
            chk("rr_idle", cdb_en, 1'b0);
        end

        stall = 1'b1;
        wb_valid = 3'b001;
        put(0, 5'h11, 32'h1011);
        tick();
        chk("bp_ready1", wb_ready, 3'b111);
        put(0, 5'h12, 32'h1012);
        tick();
        chk_bc("bp_out", 5'h11, 2'd0);
        chk("bp_ready2", wb_ready, 3'b111);
        put(0, 5'h13, 32'h1013);
        tick();
        chk("bp_full", wb_ready, 3'b110);
        chk_bc("bp_hold1", 5'h11, 2'd0);
        wb_valid = 3'b000;
        tick();
        chk("bp_full2", wb_ready, 3'b110);
        chk_bc("bp_hold2", 5'h11, 2'd0);
        stall = 1'b0;
        tick();
        chk_bc("bp_order2", 5'h12, 2'd0);
        chk("bp_ready_back", wb_ready, 3'b111);
        tick();
        chk_bc("bp_order3", 5'h13, 2'd0);
        tick();
        chk("bp_idle", cdb_en, 1'b0);

        put(0, 5'h0B, 32'hB);
        put(1, 5'd9, 32'h9);
        put(2, 5'h0A, 32'hA);
        wb_valid = 3'b111;
        tick();
        wb_valid = 3'b000;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_bc("stall_hold", 5'd9, 2'd1);
            chk("stall_hold_value", cdb_value, 32'h9);
        end
        stall = 1'b0;
        tick();
        chk_bc("stall_next", 5'h0A, 2'd2);
        tick();
        chk_bc("stall_next2", 5'h0B, 2'd0);
        tick();
        chk("stall_idle", cdb_en, 1'b0);

        put(0, 5'h15, 32'h15);
        put(1, 5'h16, 32'h16);
        put(2, 5'h17, 32'h17);
        wb_valid = 3'b111;
        stall = 1'b1;
        tick();
        wb_valid = 3'b000;
        tick();
        chk_bc("pre_rst", 5'h16, 2'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_en", cdb_en, 1'b0);
        chk("arst_tag", cdb_tag, 5'd0);
        chk("arst_value", cdb_value, 32'd0);
        chk("arst_ch", cdb_ch, 2'd0);
        chk("arst_ready", wb_ready, 3'b000);
        tick();
        tick();
        chk("arst_ready_hold", wb_ready, 3'b000);
        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_discard", cdb_en, 1'b0);
        end

        for (int c = 0; c < 3; c++) begin
            seq[c] = 0;
            exp_seq[c] = 0;
            grants[c] = 0;
            put(c, stag(c, 0), sval(c, 0));
        end
        wb_valid = 3'b111;
        for (int n = 0; n < 300; n++) begin
            acc = wb_valid & wb_ready;
            tick();
            for (int c = 0; c < 3; c++) begin
                if (acc[c]) begin
                    seq[c]++;
                    put(c, stag(c, seq[c]), sval(c, seq[c]));
                end
            end
            if (cdb_en) sb(1'b1);
        end
        wb_valid = 3'b000;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (cdb_en) sb(1'b0);
        end
        total_win = grants[0] + grants[1] + grants[2];
        chk("soak_tput", (total_win >= 297), 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("soak_fair", (grants[c] >= 99 && grants[c] <= 101), 1'b1);
            chk("soak_no_loss", exp_seq[c], seq[c]);
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
